// File: rtl/vproc_queue_ext.sv
// Single-clock FIFO for decoupling vector pipeline stages. Provides an occupancy
// count, an almost-full flag, synchronous flush and an optional fall-through bypass.
module vproc_queue_ext #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter bit FALL_THROUGH = 1'b0,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             sync_rst_i,
  input  logic             flush_i,
  output logic             enq_ready_o,
  input  logic             enq_valid_i,
  input  logic [WIDTH-1:0] enq_data_i,
  input  logic             deq_ready_i,
  output logic             deq_valid_o,
  output logic [WIDTH-1:0] deq_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             almost_full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);

  if (DEPTH < 1) begin : g_err_depth
    $error("vproc_queue_ext: DEPTH must be at least 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_err_afull
    $error("vproc_queue_ext: AFULL_THRESH must lie in 1..DEPTH");
  end

  // Explicit wrap keeps non-power-of-two depths inside the storage array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             almost_full_q, almost_full_d;
  logic             clear, empty, full, enq_fire, deq_fire, bypass;

  // Handshake generation; reset or flush blocks both sides for the cycle.
  always_comb begin
    clear       = sync_rst_i | flush_i;
    empty       = (count_q == {CNT_W{1'b0}});
    full        = (count_q == CNT_FULL);
    enq_ready_o = ~clear & ~full;
    if (FALL_THROUGH && empty) begin
      deq_valid_o = ~clear & enq_valid_i;
      deq_data_o  = enq_data_i;
    end else begin
      deq_valid_o = ~clear & ~empty;
      deq_data_o  = mem_q[rd_ptr_q];
    end
    enq_fire = enq_valid_i & enq_ready_o;
    deq_fire = deq_valid_o & deq_ready_i;
    bypass   = FALL_THROUGH & empty & enq_fire & deq_fire;
  end

  // Next-state for pointers, occupancy and the almost-full flag.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else if (!bypass) begin
      if (enq_fire) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_fire) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end else begin
      count_d = count_q;
    end
    almost_full_d = (count_d >= CNT_AFULL);
  end

  // Payload storage; bypassed entries never touch the array.
  always_ff @(posedge clk_i) begin
    if (enq_fire && !bypass) begin
      mem_q[wr_ptr_q] <= enq_data_i;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      almost_full_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign count_o       = count_q;
  assign almost_full_o = almost_full_q;

endmodule

// File: tb/tb_vproc_queue_ext.sv
// Bench for vproc_queue_ext: four configurations checked every cycle against a
// queue-based reference model, plus directed scenarios with literal expectations.
module tb_vproc_queue_ext;

  logic       clk = 1'b0;
  logic       rst;
  logic       ev [4];
  logic       dr [4];
  logic       fl [4];
  logic [7:0] ed [4];
  logic       er [4];
  logic       dv [4];
  logic [7:0] dd [4];
  logic       af [4];
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] cnt_c;
  logic [0:0] cnt_d;
  logic [2:0] cnt [4];

  int depth_p [4] = '{4, 3, 4, 1};
  bit ft_p    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int thr_p   [4] = '{3, 2, 3, 1};

  logic [7:0] mq [4][$];
  bit mon_en = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vproc_queue_ext #(.WIDTH(8), .DEPTH(4), .FALL_THROUGH(1'b0)) u_a (
    .clk_i(clk), .sync_rst_i(rst), .flush_i(fl[0]), .enq_ready_o(er[0]),
    .enq_valid_i(ev[0]), .enq_data_i(ed[0]), .deq_ready_i(dr[0]), .deq_valid_o(dv[0]),
    .deq_data_o(dd[0]), .count_o(cnt_a), .almost_full_o(af[0]));
  vproc_queue_ext #(.WIDTH(8), .DEPTH(3), .FALL_THROUGH(1'b0)) u_b (
    .clk_i(clk), .sync_rst_i(rst), .flush_i(fl[1]), .enq_ready_o(er[1]),
    .enq_valid_i(ev[1]), .enq_data_i(ed[1]), .deq_ready_i(dr[1]), .deq_valid_o(dv[1]),
    .deq_data_o(dd[1]), .count_o(cnt_b), .almost_full_o(af[1]));
  vproc_queue_ext #(.WIDTH(8), .DEPTH(4), .FALL_THROUGH(1'b1)) u_c (
    .clk_i(clk), .sync_rst_i(rst), .flush_i(fl[2]), .enq_ready_o(er[2]),
    .enq_valid_i(ev[2]), .enq_data_i(ed[2]), .deq_ready_i(dr[2]), .deq_valid_o(dv[2]),
    .deq_data_o(dd[2]), .count_o(cnt_c), .almost_full_o(af[2]));
  vproc_queue_ext #(.WIDTH(8), .DEPTH(1), .FALL_THROUGH(1'b0), .AFULL_THRESH(1)) u_d (
    .clk_i(clk), .sync_rst_i(rst), .flush_i(fl[3]), .enq_ready_o(er[3]),
    .enq_valid_i(ev[3]), .enq_data_i(ed[3]), .deq_ready_i(dr[3]), .deq_valid_o(dv[3]),
    .deq_data_o(dd[3]), .count_o(cnt_d), .almost_full_o(af[3]));

  always_comb begin
    cnt[0] = cnt_a;
    cnt[1] = {1'b0, cnt_b};
    cnt[2] = cnt_c;
    cnt[3] = {2'b00, cnt_d};
  end

  task automatic check(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected outputs from occupancy and inputs, then next state.
  always @(negedge clk) begin
    bit rf, xr, xv, ef, df;
    logic [7:0] xd;
    int n;
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        n  = mq[i].size();
        rf = rst || fl[i];
        xr = !rf && (n != depth_p[i]);
        if (ft_p[i] && n == 0) begin
          xv = !rf && ev[i];
          xd = ed[i];
        end else begin
          xv = !rf && (n != 0);
          xd = (n != 0) ? mq[i][0] : 8'h00;
        end
        check("enq_ready", i, 32'(er[i]), 32'(xr));
        check("deq_valid", i, 32'(dv[i]), 32'(xv));
        if (xv) check("deq_data", i, 32'(dd[i]), 32'(xd));
        check("count", i, 32'(cnt[i]), 32'(n));
        check("almost_full", i, 32'(af[i]), 32'(n >= thr_p[i]));
        if (rf) begin
          mq[i].delete();
        end else begin
          ef = ev[i] && xr;
          df = xv && dr[i];
          if (!(ft_p[i] && n == 0 && ef && df)) begin
            if (df) void'(mq[i].pop_front());
            if (ef) mq[i].push_back(ed[i]);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] drain [4];
    drain = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev[i] = 1'b0; dr[i] = 1'b0; fl[i] = 1'b0; ed[i] = 8'h00;
    end
    @(posedge clk);
    #1 mon_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_rst_ready", 0, 32'(er[0]), 32'd1);
    check("lit_rst_valid", 0, 32'(dv[0]), 32'd0);
    check("lit_rst_count", 0, 32'(cnt[0]), 32'd0);
    check("lit_rst_afull", 0, 32'(af[0]), 32'd0);
    tick();

    // Fill DEPTH=4 without draining.
    for (int k = 0; k < 4; k++) begin
      ev[0] = 1'b1; ed[0] = 8'(8'hA0 + k);
      @(negedge clk);
      check("lit_fill_count", 0, 32'(cnt[0]), 32'(k));
      check("lit_fill_afull", 0, 32'(af[0]), 32'(k >= 3));
      tick();
    end
    ev[0] = 1'b0;
    @(negedge clk);
    check("lit_full_count", 0, 32'(cnt[0]), 32'd4);
    check("lit_full_ready", 0, 32'(er[0]), 32'd0);
    check("lit_full_afull", 0, 32'(af[0]), 32'd1);
    tick();

    // Full with enq and deq together: only the dequeue fires.
    ev[0] = 1'b1; ed[0] = 8'hB0; dr[0] = 1'b1;
    @(negedge clk);
    check("lit_fullboth_ready", 0, 32'(er[0]), 32'd0);
    check("lit_fullboth_data", 0, 32'(dd[0]), 32'hA0);
    tick();
    dr[0] = 1'b0;
    @(negedge clk);
    check("lit_after_deq_count", 0, 32'(cnt[0]), 32'd3);
    check("lit_after_deq_ready", 0, 32'(er[0]), 32'd1);
    tick();
    ev[0] = 1'b0;
    @(negedge clk);
    check("lit_refill_count", 0, 32'(cnt[0]), 32'd4);
    tick();
    dr[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lit_drain_data", 0, 32'(dd[0]), 32'(drain[k]));
      tick();
    end
    dr[0] = 1'b0;
    @(negedge clk);
    check("lit_drained_count", 0, 32'(cnt[0]), 32'd0);
    tick();

    // Flush with a pending enqueue.
    for (int k = 0; k < 3; k++) begin
      ev[0] = 1'b1; ed[0] = 8'(8'hC0 + k);
      tick();
    end
    ed[0] = 8'hEE; fl[0] = 1'b1;
    @(negedge clk);
    check("lit_flush_ready", 0, 32'(er[0]), 32'd0);
    check("lit_flush_valid", 0, 32'(dv[0]), 32'd0);
    tick();
    fl[0] = 1'b0; ev[0] = 1'b0;
    @(negedge clk);
    check("lit_flushed_count", 0, 32'(cnt[0]), 32'd0);
    check("lit_flushed_valid", 0, 32'(dv[0]), 32'd0);
    tick();
    ev[0] = 1'b1; ed[0] = 8'hD0;
    tick();
    ev[0] = 1'b0; dr[0] = 1'b1;
    @(negedge clk);
    check("lit_post_flush_data", 0, 32'(dd[0]), 32'hD0);
    tick();
    dr[0] = 1'b0;

    // Reset together with flush while full.
    for (int k = 0; k < 4; k++) begin
      ev[0] = 1'b1; ed[0] = 8'(8'hE0 + k);
      tick();
    end
    ev[0] = 1'b0; rst = 1'b1; fl[0] = 1'b1;
    tick();
    rst = 1'b0; fl[0] = 1'b0;
    @(negedge clk);
    check("lit_rstfl_count", 0, 32'(cnt[0]), 32'd0);
    check("lit_rstfl_ready", 0, 32'(er[0]), 32'd1);
    check("lit_rstfl_afull", 0, 32'(af[0]), 32'd0);
    tick();
    ev[0] = 1'b1; ed[0] = 8'h11;
    tick();
    ev[0] = 1'b0; dr[0] = 1'b1;
    @(negedge clk);
    check("lit_rstfl_data", 0, 32'(dd[0]), 32'h11);
    tick();
    dr[0] = 1'b0;

    // DEPTH=3: steady simultaneous traffic across pointer wrap.
    ev[1] = 1'b1; ed[1] = 8'h00;
    tick();
    ed[1] = 8'h01;
    tick();
    dr[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ed[1] = 8'(k + 2);
      @(negedge clk);
      check("lit_d3_count", 1, 32'(cnt[1]), 32'd2);
      check("lit_d3_data", 1, 32'(dd[1]), 32'(k));
      check("lit_d3_nox", 1, 32'($isunknown(dd[1])), 32'd0);
      tick();
    end
    ev[1] = 1'b0;
    tick();
    tick();
    dr[1] = 1'b0;

    // Fall-through: bypass, then store.
    ev[2] = 1'b1; ed[2] = 8'h5A; dr[2] = 1'b1;
    @(negedge clk);
    check("lit_ft_valid", 2, 32'(dv[2]), 32'd1);
    check("lit_ft_data", 2, 32'(dd[2]), 32'h5A);
    check("lit_ft_count", 2, 32'(cnt[2]), 32'd0);
    tick();
    dr[2] = 1'b0;
    @(negedge clk);
    check("lit_ft_bypass_count", 2, 32'(cnt[2]), 32'd0);
    tick();
    ev[2] = 1'b0;
    @(negedge clk);
    check("lit_ft_stored_count", 2, 32'(cnt[2]), 32'd1);
    check("lit_ft_stored_data", 2, 32'(dd[2]), 32'h5A);
    tick();
    dr[2] = 1'b1;
    tick();
    dr[2] = 1'b0;
    @(negedge clk);
    check("lit_ft_empty_count", 2, 32'(cnt[2]), 32'd0);
    tick();

    // DEPTH=1: alternates full/empty, no same-cycle refill.
    ev[3] = 1'b1; ed[3] = 8'h70; dr[3] = 1'b1;
    @(negedge clk);
    check("lit_d1_ready0", 3, 32'(er[3]), 32'd1);
    tick();
    ed[3] = 8'h71;
    @(negedge clk);
    check("lit_d1_ready1", 3, 32'(er[3]), 32'd0);
    check("lit_d1_data", 3, 32'(dd[3]), 32'h70);
    tick();
    ed[3] = 8'h72;
    @(negedge clk);
    check("lit_d1_empty", 3, 32'(dv[3]), 32'd0);
    tick();
    ed[3] = 8'h73;
    tick();
    ev[3] = 1'b0;
    tick();
    dr[3] = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
